// File: rtl/mem_map_arbiter.sv
// Two-port arbiter in front of the memory map: serialises core (port 0) and
// loader (port 1) requests, one strobe per transaction, done pulse per owner.
// Ports: clk/rst; m{0,1}_req/we/addr/wdata in, m{0,1}_done out; rdata out;
// mem_re/mem_we/mem_addr/mem_wdata out, mem_rdata in; busy, owner out.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on ties (else port 0).
module mem_map_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  state_t     state;
  state_t     state_nx;
  logic       we_q;
  logic [3:0] cnt;
  logic       any;
  logic       tie;
  logic       grant;

  assign any  = m0_req | m1_req;
  assign tie  = m0_req & m1_req;
  assign busy = (state != IDLE);

`ifdef ARB_ROUND_ROBIN_EN
  logic last;

  // Resets to 1 so the first tie goes to port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (state == IDLE && tie) begin
      last <= grant;
    end
  end

  assign grant = tie ? ~last : ~m0_req;
`else
  assign grant = ~m0_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    m0_done  = 1'b0;
    m1_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        mem_re   = ~we_q;
        mem_we   = we_q;
        state_nx = we_q ? DONE : WAIT;
      end
      WAIT: begin
        // <= guards against a zero count from an out-of-range latency.
        if (cnt <= 4'd1) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        m0_done  = ~owner;
        m1_done  = owner;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      owner     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      cnt       <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            owner     <= grant;
            we_q      <= grant ? m1_we : m0_we;
            mem_addr  <= grant ? m1_addr : m0_addr;
            mem_wdata <= grant ? m1_wdata : m0_wdata;
          end
        end
        ISSUE: begin
          cnt <= LAT4;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            rdata <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_map_arbiter.sv
// Bench for mem_map_arbiter: directed steps then random traffic, checked
// cycle by cycle against a transaction-level model.
module tb_mem_map_arbiter;

  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req;
  logic [1:0]        we;
  logic [1:0][31:0]  addr;
  logic [1:0][31:0]  wdata;
  logic              m0_done;
  logic              m1_done;
  logic [31:0]       rdata;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              busy;
  logic              owner;

  mem_map_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .MEM_LAT(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (req[0]),
    .m0_we    (we[0]),
    .m0_addr  (addr[0]),
    .m0_wdata (wdata[0]),
    .m0_done  (m0_done),
    .m1_req   (req[1]),
    .m1_we    (we[1]),
    .m1_addr  (addr[1]),
    .m1_wdata (wdata[1]),
    .m1_done  (m1_done),
    .rdata    (rdata),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // transaction-level model
  bit          act = 1'b0;
  int          rel = 0;
  bit          tw = 1'b0;
  bit          towner = 1'b0;
  logic [31:0] taddr = '0;
  bit          lg = 1'b1;
  logic        m_owner = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;

  // event recorders
  int last_iss = -1;
  int n_iss = 0;
  int last_done [2] = '{-1, -1};
  int done_cnt [2] = '{0, 0};
  bit iss_q [$];
  logic [1:0] hold = 2'b00;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1234_5658;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic        e_re;
    logic        e_we;
    logic [1:0]  e_done;
    logic [1:0]  obs;
    logic [31:0] rd;
    int          len;
    int          g;
    e_re   = 1'b0;
    e_we   = 1'b0;
    e_done = 2'b00;
    rd     = $urandom;
    len    = tw ? 2 : 2 + LAT;
    if (act) begin
      if (rel == 1) begin
        e_we = tw;
        e_re = !tw;
      end
      if (rel == len) e_done[towner] = 1'b1;
      if (!tw && rel == 1 + LAT) rd = memf(taddr);
    end
    mem_rdata = rd;
    @(negedge clk);
    chk("mem_re", mem_re, e_re);
    chk("mem_we", mem_we, e_we);
    chk("busy", busy, act);
    chk("m0_done", m0_done, e_done[0]);
    chk("m1_done", m1_done, e_done[1]);
    chk("owner", owner, m_owner);
    chk("rdata", rdata, m_rdata);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    obs = {m1_done, m0_done};
    if (mem_re || mem_we) begin
      last_iss = cyc;
      n_iss++;
      iss_q.push_back(owner);
    end
    for (int p = 0; p < 2; p++) begin
      if (obs[p]) begin
        last_done[p] = cyc;
        done_cnt[p]++;
      end
    end
    if (rst) begin
      act = 1'b0;
      lg = 1'b1;
      m_owner = 1'b0;
      m_rdata = '0;
      m_addr = '0;
      m_wdata = '0;
    end else if (act) begin
      if (!tw && rel == 1 + LAT) m_rdata = rd;
      if (rel == len) act = 1'b0;
      else rel++;
    end else if (req != 2'b00) begin
      g = req[0] ? 0 : 1;
`ifdef ARB_ROUND_ROBIN_EN
      if (req == 2'b11) begin
        g = lg ? 0 : 1;
        lg = g[0];
      end
`endif
      act = 1'b1;
      rel = 1;
      tw = we[g];
      towner = g[0];
      taddr = addr[g];
      m_owner = g[0];
      m_addr = addr[g];
      m_wdata = wdata[g];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 2; p++) begin
      if (obs[p] && !hold[p]) req[p] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (act || req != 2'b00); i++) step();
    step();
  endtask

  initial begin
    int t0;
    int tr;
    int d;
    int n;
    bit exp_g [4];
    rst = 1'b1;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    chk("rst_owner", owner, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // single port-0 write
    t0 = cyc;
    req[0] = 1'b1;
    we[0] = 1'b1;
    addr[0] = 32'h10;
    wdata[0] = 32'hDEAD_BEEF;
    repeat (4) step();
    chk("t1_we_cyc", last_iss, t0 + 1);
    chk("t1_done_cyc", last_done[0], t0 + 2);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    drain();

    // port-1 read
    t0 = cyc;
    d = done_cnt[0];
    req[1] = 1'b1;
    we[1] = 1'b0;
    addr[1] = 32'h20;
    repeat (LAT + 4) step();
    chk("t2_done_cyc", last_done[1], t0 + 2 + LAT);
    chk("t2_rdata", rdata, 32'h1234_5678);
    chk("t2_no_done0", done_cnt[0], d);
    drain();

    // continuous reads from both ports
    hold = 2'b11;
    req = 2'b11;
    we = 2'b00;
    addr[0] = 32'h100;
    addr[1] = 32'h200;
    iss_q.delete();
    for (int i = 0; i < 200 && iss_q.size() < 4; i++) step();
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_grant%0d", i),
          (i < iss_q.size()) ? 32'(iss_q[i]) : 32'd2, 32'(exp_g[i]));
    end
    hold = 2'b00;
    req = 2'b00;
    drain();

    // port 0 drops req during ISSUE
    t0 = cyc;
    req[0] = 1'b1;
    we[0] = 1'b0;
    addr[0] = 32'h40;
    step();
    req[0] = 1'b0;
    n = n_iss;
    repeat (LAT + 4) step();
    chk("t4_done_cyc", last_done[0], t0 + 2 + LAT);
    chk("t4_issues", n_iss, n + 1);
    drain();

    // reset during WAIT with req held
    d = done_cnt[0];
    req[0] = 1'b1;
    we[0] = 1'b0;
    addr[0] = 32'h44;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tr = cyc;
    chk("t5_busy", busy, 1'b0);
    chk("t5_rdata", rdata, 32'h0);
    chk("t5_mem_addr", mem_addr, 32'h0);
    chk("t5_no_done", done_cnt[0], d);
    repeat (LAT + 3) step();
    chk("t5_reissue", last_iss, tr + 1);
    chk("t5_done_cyc", last_done[0], tr + 2 + LAT);
    chk("t5_done_cnt", done_cnt[0], d + 1);
    drain();

    // port 1 arrives during port 0 WAIT
    req[0] = 1'b1;
    we[0] = 1'b0;
    addr[0] = 32'h48;
    step();
    step();
    req[1] = 1'b1;
    we[1] = 1'b1;
    addr[1] = 32'h50;
    wdata[1] = $urandom;
    repeat (LAT + 6) step();
    chk("t6_issue_gap", last_iss, last_done[0] + 2);
    chk("t6_owner", owner, 1'b1);
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] && $urandom_range(2) == 0) begin
          req[p] = 1'b1;
          we[p] = 1'($urandom);
          addr[p] = $urandom;
          wdata[p] = $urandom;
        end else if (req[p] && busy && $urandom_range(15) == 0) begin
          req[p] = 1'b0;
        end
        hold[p] = ($urandom_range(3) == 0);
      end
      rst = ($urandom_range(96) == 0);
      step();
    end
    rst = 1'b0;
    hold = 2'b00;
    req = 2'b00;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
